max_pool_2x2: RTL

MAX_POOL_2X2 -- requirements
Module: max_pool_2x2

---
 rtl/max_pool_2x2.sv | 113 +++++++++++
 1 files changed

// File: rtl/max_pool_2x2.sv
// 2x2 max pooling over a DIM x DIM raster-order frame.
// Even rows fold each horizontal pixel pair into a half-width line buffer;
// odd rows combine their own pair with the buffered pair and emit one
// pooled pixel per completed window, one cycle after the completing input.
module max_pool_2x2 #(
  parameter int DIM = 24,
  parameter int W   = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] pxl_in,
  input  logic         in_valid,
  output logic [W-1:0] pxl_out,
  output logic         out_valid,
  output logic         frame_done
);

  localparam int CW   = $clog2(DIM);
  localparam int AW   = CW - 1;
  localparam int HALF = DIM / 2;

  logic [CW-1:0] col_q, col_d;
  logic [CW-1:0] row_q, row_d;
  logic [W-1:0]  hold_q, hold_d;
  logic [W-1:0]  pxl_out_q, pxl_out_d;
  logic          out_valid_q, out_valid_d;
  logic          frame_done_q, frame_done_d;

  // Line buffer holds the horizontal pair maxima of the last even row.
  logic [W-1:0]  linebuf [0:HALF-1];
  logic [W-1:0]  lb_rd_q;

  logic [AW-1:0] lb_addr;
  logic          col_odd, row_odd, last_col, last_row;
  logic          lb_we, lb_re;
  logic [W-1:0]  pair_max, quad_max;

  assign lb_addr  = col_q[CW-1:1];
  assign col_odd  = col_q[0];
  assign row_odd  = row_q[0];
  assign last_col = (col_q == CW'(DIM - 1));
  assign last_row = (row_q == CW'(DIM - 1));

  // Unsigned maxima: horizontal pair, then pair against the buffered pair.
  assign pair_max = (pxl_in > hold_q) ? pxl_in : hold_q;
  assign quad_max = (pair_max > lb_rd_q) ? pair_max : lb_rd_q;

  // Write on even-row odd columns; on odd rows prefetch the entry at the
  // even column so the registered read is ready for the odd column.
  // Writes and reads never target the same row, so no bypass is needed.
  assign lb_we = in_valid && !reset && !row_odd &&  col_odd;
  assign lb_re = in_valid && !reset &&  row_odd && !col_odd;

  // Next-state: counters, hold register and output stage move only on valid pixels.
  always_comb begin
    col_d        = col_q;
    row_d        = row_q;
    hold_d       = hold_q;
    pxl_out_d    = pxl_out_q;
    out_valid_d  = 1'b0;
    frame_done_d = 1'b0;
    if (in_valid) begin
      if (last_col) begin
        col_d = '0;
        row_d = last_row ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
      if (!col_odd) begin
        hold_d = pxl_in;
      end
      if (row_odd && col_odd) begin
        pxl_out_d    = quad_max;
        out_valid_d  = 1'b1;
        frame_done_d = last_row && last_col;
      end
    end
  end

  // Control and output registers with asynchronous clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      col_q        <= '0;
      row_q        <= '0;
      hold_q       <= '0;
      pxl_out_q    <= '0;
      out_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      col_q        <= col_d;
      row_q        <= row_d;
      hold_q       <= hold_d;
      pxl_out_q    <= pxl_out_d;
      out_valid_q  <= out_valid_d;
      frame_done_q <= frame_done_d;
    end
  end

  // Line buffer storage with registered read; contents are always rewritten before use.
  always_ff @(posedge clk) begin
    if (lb_we) begin
      linebuf[lb_addr] <= pair_max;
    end
    if (lb_re) begin
      lb_rd_q <= linebuf[lb_addr];
    end
  end

  assign pxl_out    = pxl_out_q;
  assign out_valid  = out_valid_q;
  assign frame_done = frame_done_q;

endmodule
